multiplier_pipelined_param: RTL and testbench



---
 rtl/multiplier_pipelined_param_if.sv | 23 ++
 rtl/multiplier_pipelined_param.sv | 97 +++++++++
 tb/tb_multiplier_pipelined_param.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_pipelined_param_if.sv
// Operation/result bundle for the pipelined multiplier.
// The requester uses the master modport; the multiplier uses slave.
interface multiplier_pipelined_param_if #(
  parameter int WIDTH = 32
);
  logic                   stall;
  logic                   in_valid;
  logic                   is_signed;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   out_valid;
  logic [2*WIDTH-1:0]     r;

  modport master (
    output stall, in_valid, is_signed, a, b,
    input  out_valid, r
  );

  modport slave (
    input  stall, in_valid, is_signed, a, b,
    output out_valid, r
  );
endinterface

// File: rtl/multiplier_pipelined_param.sv
// Three-stage WIDTH x WIDTH multiplier: sign/magnitude, half-width partial products,
// then recombination with sign restore. One operation per cycle, global stall.
module multiplier_pipelined_param #(
  parameter int WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  multiplier_pipelined_param_if.slave bus
);

  localparam int HALF = WIDTH / 2;
  localparam logic [2*WIDTH-1:0] ONE2 = {{(2*WIDTH-1){1'b0}}, 1'b1};

  // Most-negative input maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             take_abs);
    logic [WIDTH-1:0] res;
    if (take_abs && x[WIDTH-1]) begin
      res = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      res = x;
    end
    return res;
  endfunction

  logic                 v1_q, v2_q, v3_q;
  logic                 neg1_q, neg2_q;
  logic [WIDTH-1:0]     a1_q, b1_q;
  logic [WIDTH-1:0]     ll_q, hl_q, lh_q, hh_q;
  logic [2*WIDTH-1:0]   r_q;

  logic                 neg1_d;
  logic [WIDTH-1:0]     a1_d, b1_d;
  logic [WIDTH-1:0]     ll_d, hl_d, lh_d, hh_d;
  logic [2*WIDTH-1:0]   p_d, r_d;

  // Next-state datapath for all three stages.
  always_comb begin
    a1_d   = magnitude(bus.a, bus.is_signed);
    b1_d   = magnitude(bus.b, bus.is_signed);
    neg1_d = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);

    ll_d = {{HALF{1'b0}}, a1_q[HALF-1:0]}     * {{HALF{1'b0}}, b1_q[HALF-1:0]};
    hl_d = {{HALF{1'b0}}, a1_q[WIDTH-1:HALF]} * {{HALF{1'b0}}, b1_q[HALF-1:0]};
    lh_d = {{HALF{1'b0}}, a1_q[HALF-1:0]}     * {{HALF{1'b0}}, b1_q[WIDTH-1:HALF]};
    hh_d = {{HALF{1'b0}}, a1_q[WIDTH-1:HALF]} * {{HALF{1'b0}}, b1_q[WIDTH-1:HALF]};

    p_d = {hh_q, {WIDTH{1'b0}}}
        + {{WIDTH{1'b0}}, ll_q}
        + {{HALF{1'b0}}, hl_q, {HALF{1'b0}}}
        + {{HALF{1'b0}}, lh_q, {HALF{1'b0}}};

    // A zero magnitude negates back to zero, so -0 never appears.
    if (neg2_q) begin
      r_d = ~p_d + ONE2;
    end else begin
      r_d = p_d;
    end
  end

  // Pipeline registers; stall freezes everything, r only loads on a valid slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      neg1_q <= 1'b0;
      neg2_q <= 1'b0;
      a1_q   <= {WIDTH{1'b0}};
      b1_q   <= {WIDTH{1'b0}};
      ll_q   <= {WIDTH{1'b0}};
      hl_q   <= {WIDTH{1'b0}};
      lh_q   <= {WIDTH{1'b0}};
      hh_q   <= {WIDTH{1'b0}};
      r_q    <= {(2*WIDTH){1'b0}};
    end else if (!bus.stall) begin
      v1_q   <= bus.in_valid;
      neg1_q <= neg1_d;
      a1_q   <= a1_d;
      b1_q   <= b1_d;
      v2_q   <= v1_q;
      neg2_q <= neg1_q;
      ll_q   <= ll_d;
      hl_q   <= hl_d;
      lh_q   <= lh_d;
      hh_q   <= hh_d;
      v3_q   <= v2_q;
      if (v2_q) begin
        r_q <= r_d;
      end
    end
  end

  assign bus.out_valid = v3_q;
  assign bus.r         = r_q;

endmodule

// File: tb/tb_multiplier_pipelined_param.sv
// Scoreboard bench for the pipelined multiplier: WIDTH=32 and WIDTH=16 instances.
module tb_multiplier_pipelined_param;

  typedef struct {
    logic        v;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic        st;
    logic [63:0] exp;
  } op_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  multiplier_pipelined_param_if #(.WIDTH(32)) if32();
  multiplier_pipelined_param_if #(.WIDTH(16)) if16();

  multiplier_pipelined_param #(.WIDTH(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(if32));
  multiplier_pipelined_param #(.WIDTH(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(if16));

  int tests = 0;
  int fails = 0;
  logic [63:0] sb32[$];
  logic [31:0] sb16[$];
  logic        obs_st32 = 1'b0;
  logic        prev_ov32 = 1'b0;
  logic [63:0] prev_r32 = 64'd0;
  logic [31:0] prev_r16 = 32'd0;

  // Reference product: sign- or zero-extend to 64 bits, keep the low 64 bits.
  function automatic logic [63:0] model32(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  function automatic op_t mk(input logic v, input logic s, input logic [31:0] a,
                             input logic [31:0] b, input logic st, input logic [63:0] exp);
    op_t o;
    o.v = v; o.s = s; o.a = a; o.b = b; o.st = st; o.exp = exp;
    return o;
  endfunction

  task automatic tick32(input op_t op);
    @(negedge clk);
    obs_st32 = if32.stall;
    if32.in_valid  = op.v;
    if32.is_signed = op.s;
    if32.a         = op.a;
    if32.b         = op.b;
    if32.stall     = op.st;
    if (op.v && !op.st) sb32.push_back(op.exp);
  endtask

  task automatic tick16(input logic v, input logic s, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] exp);
    @(negedge clk);
    if16.in_valid  = v;
    if16.is_signed = s;
    if16.a         = a;
    if16.b         = b;
    if (v) sb16.push_back(exp);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    tests++;
    if (if32.out_valid !== 1'b0 || if32.r !== 64'd0) begin
      fails++;
      $display("FAIL reset32: out_valid=%b r=%h, expected 0 and 0", if32.out_valid, if32.r);
    end
    tests++;
    if (if16.out_valid !== 1'b0 || if16.r !== 32'd0) begin
      fails++;
      $display("FAIL reset16: out_valid=%b r=%h, expected 0 and 0", if16.out_valid, if16.r);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_unsigned_max();
    op_t ops[5];
    logic [3:0] pat = 4'd0;
    logic [63:0] e;
    ops[0] = mk(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    for (int i = 1; i < 5; i++) ops[i] = mk(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick32(ops[i]);
      if (obs_st32) begin
        tests++;
        if (if32.out_valid !== prev_ov32 || if32.r !== prev_r32) begin
          fails++; $display("FAIL umax_stall_hold: ov=%b r=%h, expected %b %h", if32.out_valid, if32.r, prev_ov32, prev_r32);
        end
      end else if (if32.out_valid) begin
        tests++;
        if (sb32.size() == 0) begin
          fails++; $display("FAIL umax_unexpected: r=%h, expected no result", if32.r);
        end else begin
          e = sb32.pop_front();
          if (if32.r !== e) begin fails++; $display("FAIL umax_result: r=%h, expected %h", if32.r, e); end
        end
      end else begin
        tests++;
        if (if32.r !== prev_r32) begin fails++; $display("FAIL umax_bubble_hold: r=%h, expected %h", if32.r, prev_r32); end
      end
      prev_ov32 = if32.out_valid; prev_r32 = if32.r;
      if (i > 0) pat = {pat[2:0], if32.out_valid};
    end
    tests++;
    if (pat !== 4'b0010) begin fails++; $display("FAIL umax_latency: pattern=%b, expected 0010", pat); end
  endtask

  task automatic test_signed();
    op_t ops[9];
    logic [7:0] pat = 8'd0;
    logic [63:0] e;
    ops[0] = mk(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'h0000_0000_0000_0001);
    ops[1] = mk(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
    ops[2] = mk(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
    ops[3] = mk(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 64'hFFFF_FFFF_8000_0000);
    ops[4] = mk(1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFB, 1'b0, 64'h0000_0000_0000_0000);
    for (int i = 5; i < 9; i++) ops[i] = mk(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 64'd0);
    for (int i = 0; i < 9; i++) begin
      tick32(ops[i]);
      if (obs_st32) begin
        tests++;
        if (if32.out_valid !== prev_ov32 || if32.r !== prev_r32) begin
          fails++; $display("FAIL signed_stall_hold: ov=%b r=%h, expected %b %h", if32.out_valid, if32.r, prev_ov32, prev_r32);
        end
      end else if (if32.out_valid) begin
        tests++;
        if (sb32.size() == 0) begin
          fails++; $display("FAIL signed_unexpected: r=%h, expected no result", if32.r);
        end else begin
          e = sb32.pop_front();
          if (if32.r !== e) begin fails++; $display("FAIL signed_result: r=%h, expected %h", if32.r, e); end
        end
      end else begin
        tests++;
        if (if32.r !== prev_r32) begin fails++; $display("FAIL signed_bubble_hold: r=%h, expected %h", if32.r, prev_r32); end
      end
      prev_ov32 = if32.out_valid; prev_r32 = if32.r;
      if (i > 0) pat = {pat[6:0], if32.out_valid};
    end
    tests++;
    if (pat !== 8'b0011_1110) begin fails++; $display("FAIL signed_pattern: pattern=%b, expected 00111110", pat); end
  endtask

  task automatic test_back_to_back();
    op_t ops[17];
    logic [15:0] pat = 16'd0;
    logic [63:0] e;
    op_t idle;
    idle = mk(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 64'd0);
    ops[0]  = mk(1'b1, 1'b0, 32'd3, 32'd4, 1'b0, 64'd12);
    ops[1]  = mk(1'b1, 1'b0, 32'd5, 32'd6, 1'b0, 64'd30);
    ops[2]  = mk(1'b1, 1'b0, 32'd7, 32'd8, 1'b0, 64'd56);
    for (int i = 3; i < 7; i++) ops[i] = idle;
    // Second pass: stall two cycles after the second issue, then once with a result showing.
    ops[7]  = mk(1'b1, 1'b0, 32'd3, 32'd4, 1'b0, 64'd12);
    ops[8]  = mk(1'b1, 1'b0, 32'd5, 32'd6, 1'b0, 64'd30);
    ops[9]  = mk(1'b1, 1'b0, 32'd7, 32'd8, 1'b1, 64'd56);
    ops[10] = mk(1'b1, 1'b0, 32'd7, 32'd8, 1'b1, 64'd56);
    ops[11] = mk(1'b1, 1'b0, 32'd7, 32'd8, 1'b0, 64'd56);
    ops[12] = idle;
    ops[13] = mk(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 64'd0);
    for (int i = 14; i < 17; i++) ops[i] = idle;
    for (int i = 0; i < 17; i++) begin
      tick32(ops[i]);
      if (obs_st32) begin
        tests++;
        if (if32.out_valid !== prev_ov32 || if32.r !== prev_r32) begin
          fails++; $display("FAIL b2b_stall_hold: ov=%b r=%h, expected %b %h", if32.out_valid, if32.r, prev_ov32, prev_r32);
        end
      end else if (if32.out_valid) begin
        tests++;
        if (sb32.size() == 0) begin
          fails++; $display("FAIL b2b_unexpected: r=%h, expected no result", if32.r);
        end else begin
          e = sb32.pop_front();
          if (if32.r !== e) begin fails++; $display("FAIL b2b_result: r=%h, expected %h", if32.r, e); end
        end
      end else begin
        tests++;
        if (if32.r !== prev_r32) begin fails++; $display("FAIL b2b_bubble_hold: r=%h, expected %h", if32.r, prev_r32); end
      end
      prev_ov32 = if32.out_valid; prev_r32 = if32.r;
      if (i > 0) pat = {pat[14:0], if32.out_valid};
    end
    tests++;
    if (pat[15:0] !== 16'b0011_1000_0001_1110) begin
      fails++; $display("FAIL b2b_pattern: pattern=%b, expected 0011100000011110", pat);
    end
    tests++;
    if (sb32.size() != 0) begin fails++; $display("FAIL b2b_lost: %0d results pending, expected 0", sb32.size()); end
  endtask

  task automatic test_mixed_bubble();
    op_t ops[6];
    logic [4:0] pat = 5'd0;
    logic [63:0] e;
    ops[0] = mk(1'b1, 1'b1, 32'hFFFF_FFFE, 32'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA);
    ops[1] = mk(1'b0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'd0);
    ops[2] = mk(1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3, 1'b0, 64'h0000_0002_FFFF_FFFA);
    for (int i = 3; i < 6; i++) ops[i] = mk(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick32(ops[i]);
      if (obs_st32) begin
        tests++;
        if (if32.out_valid !== prev_ov32 || if32.r !== prev_r32) begin
          fails++; $display("FAIL mixed_stall_hold: ov=%b r=%h, expected %b %h", if32.out_valid, if32.r, prev_ov32, prev_r32);
        end
      end else if (if32.out_valid) begin
        tests++;
        if (sb32.size() == 0) begin
          fails++; $display("FAIL mixed_unexpected: r=%h, expected no result", if32.r);
        end else begin
          e = sb32.pop_front();
          if (if32.r !== e) begin fails++; $display("FAIL mixed_result: r=%h, expected %h", if32.r, e); end
        end
      end else begin
        tests++;
        if (if32.r !== prev_r32) begin fails++; $display("FAIL mixed_bubble_hold: r=%h, expected %h", if32.r, prev_r32); end
      end
      prev_ov32 = if32.out_valid; prev_r32 = if32.r;
      if (i > 0) pat = {pat[3:0], if32.out_valid};
    end
    tests++;
    if (pat !== 5'b00101) begin fails++; $display("FAIL mixed_pattern: pattern=%b, expected 00101", pat); end
  endtask

  task automatic test_random();
    op_t cur;
    logic last_st = 1'b0;
    logic [63:0] e;
    cur = mk(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 64'd0);
    for (int i = 0; i < 70; i++) begin
      if (!last_st) begin
        cur.v = (i < 64) && ($urandom_range(0, 3) != 0);
        cur.s = $urandom_range(0, 1) == 1;
        cur.a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
        cur.b = ($urandom_range(0, 5) == 0) ? 32'h0000_0000 : $urandom;
        cur.exp = model32(cur.s, cur.a, cur.b);
      end
      cur.st = (i < 64) && ($urandom_range(0, 4) == 0);
      last_st = cur.st;
      tick32(cur);
      if (obs_st32) begin
        tests++;
        if (if32.out_valid !== prev_ov32 || if32.r !== prev_r32) begin
          fails++; $display("FAIL rand_stall_hold: ov=%b r=%h, expected %b %h", if32.out_valid, if32.r, prev_ov32, prev_r32);
        end
      end else if (if32.out_valid) begin
        tests++;
        if (sb32.size() == 0) begin
          fails++; $display("FAIL rand_unexpected: r=%h, expected no result", if32.r);
        end else begin
          e = sb32.pop_front();
          if (if32.r !== e) begin fails++; $display("FAIL rand_result: r=%h, expected %h", if32.r, e); end
        end
      end else begin
        tests++;
        if (if32.r !== prev_r32) begin fails++; $display("FAIL rand_bubble_hold: r=%h, expected %h", if32.r, prev_r32); end
      end
      prev_ov32 = if32.out_valid; prev_r32 = if32.r;
    end
    tests++;
    if (sb32.size() != 0) begin fails++; $display("FAIL rand_lost: %0d results pending, expected 0", sb32.size()); end
  endtask

  task automatic test_reset_midop();
    op_t idle;
    idle = mk(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 64'd0);
    tick32(mk(1'b1, 1'b0, 32'h0001_0003, 32'h0000_0007, 1'b0, 64'd0));
    tick32(mk(1'b1, 1'b1, 32'hFFFF_FFF0, 32'h0000_0009, 1'b0, 64'd0));
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    if32.in_valid = 1'b0;
    if32.stall    = 1'b1;
    #1;
    tests++;
    if (if32.out_valid !== 1'b0 || if32.r !== 64'd0) begin
      fails++; $display("FAIL midop_reset: out_valid=%b r=%h, expected 0 and 0", if32.out_valid, if32.r);
    end
    sb32.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    if32.stall = 1'b0;
    reset_n = 1'b1;
    prev_ov32 = 1'b0; prev_r32 = 64'd0;
    for (int i = 0; i < 6; i++) begin
      tick32(idle);
      tests++;
      if (if32.out_valid !== 1'b0 || if32.r !== 64'd0) begin
        fails++; $display("FAIL midop_discard: out_valid=%b r=%h, expected 0 and 0", if32.out_valid, if32.r);
      end
    end
  endtask

  task automatic test_width16();
    logic [4:0] pat = 5'd0;
    logic [31:0] e;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       tick16(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        1:       tick16(1'b1, 1'b1, 16'h8000, 16'h7FFF, 32'hC000_8000);
        default: tick16(1'b0, 1'b0, 16'h0000, 16'h0000, 32'h0000_0000);
      endcase
      if (if16.out_valid) begin
        tests++;
        if (sb16.size() == 0) begin
          fails++; $display("FAIL w16_unexpected: r=%h, expected no result", if16.r);
        end else begin
          e = sb16.pop_front();
          if (if16.r !== e) begin fails++; $display("FAIL w16_result: r=%h, expected %h", if16.r, e); end
        end
      end else begin
        tests++;
        if (if16.r !== prev_r16) begin fails++; $display("FAIL w16_bubble_hold: r=%h, expected %h", if16.r, prev_r16); end
      end
      prev_r16 = if16.r;
      if (i > 0) pat = {pat[3:0], if16.out_valid};
    end
    tests++;
    if (pat !== 5'b00110) begin fails++; $display("FAIL w16_latency: pattern=%b, expected 00110", pat); end
  endtask

  initial begin
    if32.stall = 1'b0; if32.in_valid = 1'b0; if32.is_signed = 1'b0; if32.a = 32'd0; if32.b = 32'd0;
    if16.stall = 1'b0; if16.in_valid = 1'b0; if16.is_signed = 1'b0; if16.a = 16'd0; if16.b = 16'd0;
    test_reset();
    test_unsigned_max();
    test_signed();
    test_back_to_back();
    test_mixed_bubble();
    test_random();
    test_reset_midop();
    test_width16();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
